// File: rtl/frame_packer_pkg.sv
// Shared types and constants for the frame packer.
// The FSM enum only carries a CSUM state when FRAME_PACKER_CSUM_EN is defined.
package frame_packer_pkg;

    localparam int FRAMES_SENT_W = 16;

`ifdef FRAME_PACKER_CSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1
    } state_e;
`endif

endpackage

// File: rtl/frame_packer_if.sv
// Stream bus of the frame packer: unthrottled word input and a valid/ready beat output.
// The slave modport is the packer side; the master modport is its environment.
interface frame_packer_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/frame_fifo.sv
// Word FIFO with wrapping pointers and a full-range count. It also exposes the
// post-edge count and head so the packer can register its outputs without extra latency.
module frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_req,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop_req,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   count_nxt,
    output logic [DATA_WIDTH-1:0] head_nxt,
    output logic                  drop
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam int                CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ZERO_C  = {CNT_W{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [ADDR_WIDTH-1:0] rd_nxt_s;
    logic [CNT_W-1:0]      count_s;
    logic [CNT_W-1:0]      remain_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Push/pop qualification and look-ahead of count and head.
    always_comb begin
        full_s   = (count_r == DEPTH_C);
        push_s   = push_req & ~full_s;
        drop_s   = push_req & full_s;
        pop_s    = pop_req & (count_r != ZERO_C);
        rd_nxt_s = rd_ptr_r + ADDR_WIDTH'(pop_s);
        count_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        remain_s = count_r - CNT_W'(pop_s);
        // When no older word survives this edge, the new head is the word being written.
        if (count_s == ZERO_C) begin
            head_s = {DATA_WIDTH{1'b0}};
        end else if (remain_s == ZERO_C) begin
            head_s = wdata;
        end else begin
            head_s = mem_r[rd_nxt_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(push_s);
            rd_ptr_r <= rd_nxt_s;
            count_r  <= count_s;
        end
    end

    assign count     = count_r;
    assign count_nxt = count_s;
    assign head_nxt  = head_s;
    assign drop      = drop_s;

endmodule

// File: rtl/frame_packer.sv
// Packs an unthrottled word stream into FRAME_LEN-beat frames on a valid/ready output.
// Define FRAME_PACKER_CSUM_EN to append a modular-sum checksum beat to every frame.
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FRAME_LEN  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    frame_packer_if.slave            bus,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [FRAMES_SENT_W-1:0] frames_sent
);

    localparam int                CNT_W     = ADDR_WIDTH + 1;
    localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  ZERO_C    = {CNT_W{1'b0}};

    state_e                   state_r;
    state_e                   state_s;
    logic [BEAT_W-1:0]        beat_r;
    logic [BEAT_W-1:0]        beat_s;
`ifdef FRAME_PACKER_CSUM_EN
    logic [DATA_WIDTH-1:0]    csum_r;
    logic [DATA_WIDTH-1:0]    csum_s;
`endif
    logic                     out_valid_r;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic                     out_last_r;
    logic                     out_valid_s;
    logic [DATA_WIDTH-1:0]    out_data_s;
    logic                     out_last_s;
    logic                     overflow_r;
    logic                     overflow_s;
    logic [FRAMES_SENT_W-1:0] frames_sent_r;
    logic [FRAMES_SENT_W-1:0] frames_sent_s;

    logic                     hs_s;
    logic                     pop_s;
    logic [CNT_W-1:0]         fifo_count_s;
    logic [CNT_W-1:0]         fifo_count_nxt_s;
    logic [DATA_WIDTH-1:0]    fifo_head_nxt_s;
    logic                     drop_s;

    frame_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_req  (bus.in_valid),
        .wdata     (bus.in_data),
        .pop_req   (pop_s),
        .count     (fifo_count_s),
        .count_nxt (fifo_count_nxt_s),
        .head_nxt  (fifo_head_nxt_s),
        .drop      (drop_s)
    );

    // Next-state, beat counter and checksum; a pop happens only on a data-beat handshake.
    always_comb begin
        hs_s    = out_valid_r & bus.out_ready;
        pop_s   = 1'b0;
        state_s = state_r;
        beat_s  = beat_r;
`ifdef FRAME_PACKER_CSUM_EN
        csum_s  = csum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (fifo_count_s != ZERO_C) begin
                    state_s = ST_DATA;
                    beat_s  = {BEAT_W{1'b0}};
`ifdef FRAME_PACKER_CSUM_EN
                    csum_s  = {DATA_WIDTH{1'b0}};
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (hs_s) begin
                    pop_s  = 1'b1;
`ifdef FRAME_PACKER_CSUM_EN
                    csum_s = csum_r + out_data_r;
`endif
                    if (beat_r == LAST_BEAT) begin
                        beat_s  = {BEAT_W{1'b0}};
`ifdef FRAME_PACKER_CSUM_EN
                        state_s = ST_CSUM;
`else
                        state_s = ST_IDLE;
`endif
                    end else begin
                        beat_s  = beat_r + BEAT_W'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef FRAME_PACKER_CSUM_EN
            ST_CSUM: begin
                if (hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CSUM;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                beat_s  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // Output beat as it will look after this edge, so the outputs can be registered.
    always_comb begin
        out_valid_s = 1'b0;
        out_data_s  = {DATA_WIDTH{1'b0}};
        out_last_s  = 1'b0;
        case (state_s)
            ST_DATA: begin
                if (fifo_count_nxt_s != ZERO_C) begin
                    out_valid_s = 1'b1;
                    out_data_s  = fifo_head_nxt_s;
`ifdef FRAME_PACKER_CSUM_EN
                    out_last_s  = 1'b0;
`else
                    out_last_s  = (beat_s == LAST_BEAT);
`endif
                end else begin
                    out_valid_s = 1'b0;
                end
            end
`ifdef FRAME_PACKER_CSUM_EN
            ST_CSUM: begin
                out_valid_s = 1'b1;
                out_data_s  = csum_s;
                out_last_s  = 1'b1;
            end
`endif
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Sticky drop flag (a drop beats a same-cycle clear) and completed-frame counter.
    always_comb begin
        if (drop_s) begin
            overflow_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
        if (hs_s && out_last_r) begin
            frames_sent_s = frames_sent_r + FRAMES_SENT_W'(1);
        end else begin
            frames_sent_s = frames_sent_r;
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            beat_r        <= {BEAT_W{1'b0}};
`ifdef FRAME_PACKER_CSUM_EN
            csum_r        <= {DATA_WIDTH{1'b0}};
`endif
            out_valid_r   <= 1'b0;
            out_data_r    <= {DATA_WIDTH{1'b0}};
            out_last_r    <= 1'b0;
            overflow_r    <= 1'b0;
            frames_sent_r <= {FRAMES_SENT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            beat_r        <= beat_s;
`ifdef FRAME_PACKER_CSUM_EN
            csum_r        <= csum_s;
`endif
            out_valid_r   <= out_valid_s;
            out_data_r    <= out_data_s;
            out_last_r    <= out_last_s;
            overflow_r    <= overflow_s;
            frames_sent_r <= frames_sent_s;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign overflow      = overflow_r;
    assign frames_sent   = frames_sent_r;

endmodule

// File: tb/tb_frame_packer.sv
// Self-checking bench for frame_packer (DATA_WIDTH=8, ADDR_WIDTH=3, FRAME_LEN=4).
// A queue-based reference model predicts the beat stream, overflow and frame count.
module tb_frame_packer;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int FL    = 4;
    localparam int DEPTH = 8;
`ifdef FRAME_PACKER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic          is_csum;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        clr_ovf;
    logic        overflow;
    logic [15:0] frames_sent;

    frame_packer_if #(.DATA_WIDTH(DW)) bus ();

    frame_packer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_LEN  (FL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Reference model state
    beat_t         exp_q [$];
    beat_t         mon_log [$];
    beat_t         ref_log [$];
    int            occ;
    int            frames;
    logic          ovf;
    int            pos;
    logic [DW-1:0] sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mon_log.delete();
        occ    = 0;
        frames = 0;
        ovf    = 1'b0;
        pos    = 0;
        sum    = '0;
    endtask

    // An accepted word joins the expected stream; a full frame may add a checksum beat.
    task automatic model_accept(input logic [DW-1:0] d);
        beat_t b;
        b.is_csum = 1'b0;
        b.last    = (!CSUM_EN) && (pos == FL - 1);
        b.data    = d;
        exp_q.push_back(b);
        sum = sum + d;
        pos++;
        if (pos == FL) begin
            if (CSUM_EN) begin
                b.is_csum = 1'b1;
                b.last    = 1'b1;
                b.data    = sum;
                exp_q.push_back(b);
            end
            pos = 0;
            sum = '0;
        end
    endtask

    // One clock cycle: drive inputs, check the visible beat, advance model, check flags.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic rdy, input logic clr);
        logic  hs;
        logic  full;
        beat_t e;
        beat_t m;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        clr_ovf       = clr;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                check("beat_data", 32'(bus.out_data), 32'(exp_q[0].data));
                check("beat_last", 32'(bus.out_last), 32'(exp_q[0].last));
            end
        end
        hs   = bus.out_valid && rdy;
        full = (occ >= DEPTH);
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m.is_csum = e.is_csum;
            m.last    = bus.out_last;
            m.data    = bus.out_data;
            mon_log.push_back(m);
            if (!e.is_csum) occ--;
            if (e.last) frames++;
        end
        if (iv && !full) begin
            occ++;
            model_accept(d);
        end
        if (iv && full) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        @(posedge clk);
        #1;
        check("overflow", 32'(overflow), 32'(ovf));
        check("frames_sent", 32'(frames_sent), 32'(frames[15:0]));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clr_ovf       = 1'b0;
        reset_n       = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic ref_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                             input logic [DW-1:0] cs);
        logic [DW-1:0] w [4];
        beat_t b;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            b.is_csum = 1'b0;
            b.last    = (!CSUM_EN) && (i == 3);
            b.data    = w[i];
            ref_log.push_back(b);
        end
        if (CSUM_EN) begin
            b.is_csum = 1'b1;
            b.last    = 1'b1;
            b.data    = cs;
            ref_log.push_back(b);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(mon_log.size()), 32'(ref_log.size()));
        for (int i = 0; i < ref_log.size() && i < mon_log.size(); i++) begin
            check({tag, "_data"}, 32'(mon_log[i].data), 32'(ref_log[i].data));
            check({tag, "_last"}, 32'(mon_log[i].last), 32'(ref_log[i].last));
        end
        ref_log.delete();
        mon_log.delete();
    endtask

    task automatic push_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        step(1'b1, w0, 1'b1, 1'b0);
        step(1'b1, w1, 1'b1, 1'b0);
        step(1'b1, w2, 1'b1, 1'b0);
        step(1'b1, w3, 1'b1, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] rst_words [8];
        int            k;
        clk      = 1'b0;
        reset_n  = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        do_reset();

        // Basic frame: 01..04 (checksum 0A)
        mon_log.delete();
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        drain();
        check("t1_frames", 32'(frames_sent), 32'd1);
        ref_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        check_log("t1");

        // Checksum wrap: FF x4 -> FC
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drain();
        check("t2_frames", 32'(frames_sent), 32'd2);
        ref_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
        check_log("t2");

        // Overflow with no downstream ready, then clear and drain in order
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        check("t3_ovf_set", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        drain();
        k = 0;
        for (int i = 0; i < mon_log.size(); i++) begin
            if (!mon_log[i].is_csum) begin
                check("t3_order", 32'(mon_log[i].data), 32'(8'h10 + k));
                k++;
            end
        end
        check("t3_count", 32'(k), 32'd8);
        mon_log.delete();

        // Full FIFO: push and pop in the same cycle still drops; clear wins only without a drop
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        check("t4_ovf_drop_pop", 32'(overflow), 32'd1);
        check("t4_occ", 32'(occ), 32'd7);
        step(1'b0, '0, 1'b1, 1'b1);
        check("t4_ovf_clr", 32'(overflow), 32'd0);
        drain();
        mon_log.delete();

        // Reset after two beats of a frame, then a clean frame 05..08 (checksum 1A)
        rst_words[0] = 8'h31; rst_words[1] = 8'h32; rst_words[2] = 8'h33; rst_words[3] = 8'h34;
        for (int i = 0; i < 20 && mon_log.size() < 2; i++) begin
            step(i < 4, (i < 4) ? rst_words[i[1:0]] : 8'h00, 1'b1, 1'b0);
        end
        check("t5_two_beats", 32'(mon_log.size()), 32'd2);
        do_reset();
        push_frame(8'h05, 8'h06, 8'h07, 8'h08);
        drain();
        check("t5_frames", 32'(frames_sent), 32'd1);
        ref_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        check_log("t5");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 65,
                 $urandom_range(0, 19) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
